// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared states, response codes and parameter checks for the APB requester
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

    // Response code layout: bit 0 = error seen, bit 1 = aborted by timeout.
    localparam logic [1:0] RSP_OKAY    = 2'b00;
    localparam logic [1:0] RSP_SLVERR  = 2'b01;
    localparam logic [1:0] RSP_TIMEOUT = 2'b11;

    function automatic bit data_w_legal(input int w);
        return (w == 8) || (w == 16) || (w == 32);
    endfunction

endpackage

// File: rtl/apb_timeout_cnt.sv
// rtl/apb_timeout_cnt.sv - counts consecutive stalled ACCESS cycles and flags the terminal one
module apb_timeout_cnt #(
    parameter int CNT_W    = 9,
    parameter int TERMINAL = 256
) (
    input  logic pclk,
    input  logic preset,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam logic [CNT_W-1:0] LAST = (TERMINAL == 0) ? '0 : CNT_W'(TERMINAL - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    // Flags the stalled cycle that brings the count up to TERMINAL, so the abort lands on that same cycle.
    assign terminal = (TERMINAL != 0) && enable && (count == LAST);

endmodule

// File: rtl/apb_master_ctrl.sv
// rtl/apb_master_ctrl.sv - APB4 requester: command channel in, SETUP/ACCESS transfers out, response channel back
module apb_master_ctrl
    import apb_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 256,
    parameter int CNT_W          = 9
) (
    input  logic                pclk,
    input  logic                preset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [DATA_W-1:0]   cmd_wdata,
    input  logic [DATA_W/8-1:0] cmd_strb,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                rsp_timeout,
    output logic                psel,
    output logic                penable,
    output logic [ADDR_W-1:0]   paddr,
    output logic                pwrite,
    output logic [DATA_W-1:0]   pwdata,
    output logic [DATA_W/8-1:0] pstrb,
    input  logic [DATA_W-1:0]   prdata,
    input  logic                pready,
    input  logic                pslverr
);

    if (!data_w_legal(DATA_W)) begin : g_bad_data_w
        $error("apb_master_ctrl: DATA_W must be 8, 16 or 32");
    end
    if ((2 ** CNT_W) <= TIMEOUT_CYCLES) begin : g_bad_cnt_w
        $error("apb_master_ctrl: CNT_W too narrow for TIMEOUT_CYCLES");
    end

    apb_state_e state_q;
    apb_state_e state_d;
    logic [1:0] rsp_code;
    logic       cmd_fire;
    logic       tmo_en;
    logic       tmo_hit;

    assign cmd_fire    = cmd_valid && cmd_ready;
    assign tmo_en      = (state_q == ACCESS) && !pready;
    assign rsp_err     = rsp_code[0];
    assign rsp_timeout = rsp_code[1];

    apb_timeout_cnt #(
        .CNT_W    (CNT_W),
        .TERMINAL (TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .pclk     (pclk),
        .preset   (preset),
        .clear    (cmd_fire),
        .enable   (tmo_en),
        .terminal (tmo_hit)
    );

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        psel      = 1'b0;
        penable   = 1'b0;
        rsp_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_d = SETUP;
            end
            SETUP: begin
                psel    = 1'b1;
                state_d = ACCESS;
            end
            ACCESS: begin
                psel    = 1'b1;
                penable = 1'b1;
                if (pready || tmo_hit) state_d = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                // Consuming the response frees the slot, so a waiting command goes straight to SETUP.
                cmd_ready = rsp_ready;
                if (rsp_ready) state_d = cmd_valid ? SETUP : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Bus fields only move on a new command, so they hold the last transfer while idle.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            paddr  <= '0;
            pwrite <= 1'b0;
            pwdata <= '0;
            pstrb  <= '0;
        end else if (cmd_fire) begin
            paddr  <= cmd_addr;
            pwrite <= cmd_write;
            pwdata <= cmd_wdata;
            pstrb  <= cmd_write ? cmd_strb : '0;
        end
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            rsp_rdata <= '0;
            rsp_code  <= RSP_OKAY;
        end else if (state_q == ACCESS) begin
            if (pready) begin
                rsp_rdata <= pwrite ? '0 : prdata;
                rsp_code  <= pslverr ? RSP_SLVERR : RSP_OKAY;
            end else if (tmo_hit) begin
                rsp_rdata <= '0;
                rsp_code  <= RSP_TIMEOUT;
            end
        end
    end

endmodule

// File: tb/tb_apb_master_ctrl.sv
// tb/tb_apb_master_ctrl.sv - self-checking bench for apb_master_ctrl with a transaction-level model
module tb_apb_master_ctrl;

    localparam int TMO = 4;

    logic        pclk = 1'b0;
    logic        preset = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_strb = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic        psel;
    logic        penable;
    logic [31:0] paddr;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    // Completer behaviour: ready after cfg_wait stalled ACCESS cycles, or never when stuck.
    int          cfg_wait = 0;
    logic        cfg_stuck = 1'b0;
    logic        cfg_err = 1'b0;
    logic [31:0] cfg_rdata = '0;
    int          acc_cnt = 0;

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;
    int acc_at = 0;
    int rsp_cnt = 0;
    int last_rsp_cyc = 0;

    apb_master_ctrl #(
        .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TMO), .CNT_W(3)
    ) dut (
        .pclk(pclk), .preset(preset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .psel(psel), .penable(penable), .paddr(paddr), .pwrite(pwrite),
        .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata), .pready(pready),
        .pslverr(pslverr)
    );

    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc <= cyc + 1;
    always @(posedge pclk) acc_cnt <= (psel && penable && !pready) ? acc_cnt + 1 : 0;

    assign pready  = !cfg_stuck && (acc_cnt == cfg_wait);
    assign prdata  = cfg_rdata;
    assign pslverr = cfg_err;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          k;
        logic [31:0] rdata;
        logic        err;
        logic        to;
        int          acc_cyc;
    } xfer_t;

    xfer_t bus_q[$];
    xfer_t rsp_q[$];
    xfer_t last_bus;
    xfer_t last_rsp;
    xfer_t e;
    int    setup_cnt = 0;
    int    acc_len = 0;
    bit    prev_psel = 1'b0;
    bit    rsp_new = 1'b1;

    // Model: each accepted command yields one bus transfer of known ACCESS length and one response.
    always @(negedge pclk) begin
        if (preset) begin
            bus_q.delete();
            rsp_q.delete();
            last_bus  = '{default: 0};
            last_rsp  = '{default: 0};
            setup_cnt = 0;
            acc_len   = 0;
            prev_psel = 1'b0;
            rsp_new   = 1'b1;
        end else begin
            if (psel) begin
                chk("cmd_ready_busy", cmd_ready, 0);
                if (bus_q.size() == 0) begin
                    chk("psel_unexpected", psel, 0);
                end else begin
                    chk("paddr", paddr, bus_q[0].addr);
                    chk("pwrite", pwrite, bus_q[0].write);
                    chk("pwdata", pwdata, bus_q[0].wdata);
                    chk("pstrb", pstrb, bus_q[0].strb);
                    if (penable) acc_len++;
                    else setup_cnt++;
                end
            end else begin
                chk("penable_no_psel", penable, 0);
                if (prev_psel && bus_q.size() > 0) begin
                    chk("setup_len", setup_cnt, 1);
                    chk("access_len", acc_len, bus_q[0].k);
                    last_bus  = bus_q.pop_front();
                    setup_cnt = 0;
                    acc_len   = 0;
                end
                chk("hold_paddr", paddr, last_bus.addr);
                chk("hold_pwrite", pwrite, last_bus.write);
                chk("hold_pwdata", pwdata, last_bus.wdata);
                chk("hold_pstrb", pstrb, last_bus.strb);
                if (!rsp_valid) chk("cmd_ready_idle", cmd_ready, 1);
            end
            prev_psel = psel;

            if (rsp_valid) begin
                if (rsp_q.size() == 0) begin
                    chk("rsp_unexpected", rsp_valid, 0);
                end else begin
                    if (rsp_new) chk("rsp_latency", cyc - rsp_q[0].acc_cyc, rsp_q[0].k + 2);
                    chk("rsp_rdata", rsp_rdata, rsp_q[0].rdata);
                    chk("rsp_err", rsp_err, rsp_q[0].err);
                    chk("rsp_timeout", rsp_timeout, rsp_q[0].to);
                    if (rsp_ready) begin
                        last_rsp     = rsp_q.pop_front();
                        rsp_cnt      = rsp_cnt + 1;
                        last_rsp_cyc = cyc;
                    end else begin
                        chk("cmd_ready_stall", cmd_ready, 0);
                    end
                end
            end else begin
                chk("hold_rsp_rdata", rsp_rdata, last_rsp.rdata);
                chk("hold_rsp_err", rsp_err, last_rsp.err);
                chk("hold_rsp_timeout", rsp_timeout, last_rsp.to);
            end
            rsp_new = !rsp_valid || rsp_ready;

            if (cmd_valid && cmd_ready) begin
                e.addr    = cmd_addr;
                e.write   = cmd_write;
                e.wdata   = cmd_wdata;
                e.strb    = cmd_write ? cmd_strb : 4'h0;
                e.to      = cfg_stuck || (cfg_wait >= TMO);
                e.k       = e.to ? TMO : cfg_wait + 1;
                e.rdata   = (cmd_write || e.to) ? 32'h0 : cfg_rdata;
                e.err     = e.to || cfg_err;
                e.acc_cyc = cyc;
                bus_q.push_back(e);
                rsp_q.push_back(e);
            end
        end
    end

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input bit keep);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_strb  = s;
        for (int i = 0; i < 50; i++) begin
            if (cmd_ready) begin
                acc_at = cyc;
                step();
                if (!keep) cmd_valid = 1'b0;
                return;
            end
            step();
        end
        chk("issue_wait", cmd_ready, 1);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int max, output int pen);
        pen = 0;
        for (int i = 0; i < max; i++) begin
            if (rsp_valid) return;
            if (penable) pen++;
            step();
        end
        chk("rsp_wait", rsp_valid, 1);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_psel"}, psel, 0);
        chk({tag, "_penable"}, penable, 0);
        chk({tag, "_pwrite"}, pwrite, 0);
        chk({tag, "_paddr"}, paddr, 0);
        chk({tag, "_pwdata"}, pwdata, 0);
        chk({tag, "_pstrb"}, pstrb, 0);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_rsp_rdata"}, rsp_rdata, 0);
        chk({tag, "_rsp_err"}, rsp_err, 0);
        chk({tag, "_rsp_timeout"}, rsp_timeout, 0);
        chk({tag, "_cmd_ready"}, cmd_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int pen;
        int acc_list[4];
        int base;

        #1 preset = 1'b1;
        #1 check_all_zero("reset");
        repeat (2) @(posedge pclk);
        #1 preset = 1'b0;
        step();

        // Zero-wait write, pready tied high everywhere.
        cfg_wait = 0; cfg_stuck = 1'b0; cfg_err = 1'b0; cfg_rdata = 32'hFFFF_0000;
        issue(1'b1, 32'h0000_A000, 32'hDEAD_BEEF, 4'hF, 1'b0);
        chk("wr0_psel_c1", psel, 1);
        chk("wr0_penable_c1", penable, 0);
        chk("wr0_paddr", paddr, 32'h0000_A000);
        step();
        chk("wr0_penable_c2", penable, 1);
        chk("wr0_pwdata", pwdata, 32'hDEAD_BEEF);
        step();
        chk("wr0_rsp_valid_c3", rsp_valid, 1);
        chk("wr0_latency", cyc - acc_at, 3);
        chk("wr0_rdata", rsp_rdata, 0);
        chk("wr0_err", rsp_err, 0);
        step();
        chk("wr0_rsp_done", rsp_valid, 0);

        // Read with three wait states.
        cfg_wait = 3; cfg_rdata = 32'h1234_5678;
        issue(1'b0, 32'h0000_B004, 32'h5555_5555, 4'hF, 1'b0);
        wait_rsp(20, pen);
        chk("rd3_penable_cycles", pen, 4);
        chk("rd3_rdata", rsp_rdata, 32'h1234_5678);
        chk("rd3_err", rsp_err, 0);
        step();

        // Write with pslverr, response stalled for five cycles.
        cfg_wait = 0; cfg_err = 1'b1; rsp_ready = 1'b0;
        issue(1'b1, 32'h0000_C008, 32'h0BAD_F00D, 4'h3, 1'b0);
        wait_rsp(20, pen);
        for (int i = 0; i < 5; i++) begin
            chk("slv_valid", rsp_valid, 1);
            chk("slv_err", rsp_err, 1);
            chk("slv_timeout", rsp_timeout, 0);
            chk("slv_cmd_ready", cmd_ready, 0);
            step();
        end
        rsp_ready = 1'b1; cfg_err = 1'b0;
        step();
        chk("slv_valid_drop", rsp_valid, 0);
        chk("slv_err_held", rsp_err, 1);

        // Timeout: pready never rises.
        cfg_stuck = 1'b1;
        issue(1'b0, 32'h0000_D00C, 32'h0, 4'hF, 1'b0);
        wait_rsp(20, pen);
        chk("tmo_penable_cycles", pen, 4);
        chk("tmo_psel_after", psel, 0);
        chk("tmo_err", rsp_err, 1);
        chk("tmo_timeout", rsp_timeout, 1);
        chk("tmo_rdata", rsp_rdata, 0);
        step();

        // pready on the terminal cycle wins over the timeout.
        cfg_stuck = 1'b0; cfg_wait = 3; cfg_rdata = 32'hA5A5_0F0F;
        issue(1'b0, 32'h0000_D010, 32'h0, 4'hF, 1'b0);
        wait_rsp(20, pen);
        chk("edge_penable_cycles", pen, 4);
        chk("edge_err", rsp_err, 0);
        chk("edge_timeout", rsp_timeout, 0);
        chk("edge_rdata", rsp_rdata, 32'hA5A5_0F0F);
        step();

        // Back-to-back: four commands with cmd_valid held.
        cfg_wait = 0; rsp_ready = 1'b1;
        base = rsp_cnt;
        for (int i = 0; i < 4; i++) begin
            issue(i[0], 32'h0000_1000 + 32'(i * 4), 32'h1111_1111 * 32'(i + 1), 4'(1 << i), 1'b1);
            acc_list[i] = acc_at;
        end
        cmd_valid = 1'b0;
        for (int i = 0; i < 30 && rsp_cnt < base + 4; i++) step();
        chk("b2b_rsp_count", rsp_cnt - base, 4);
        for (int i = 1; i < 4; i++) chk("b2b_accept_gap", acc_list[i] - acc_list[0], 3 * i);
        chk("b2b_total_cycles", last_rsp_cyc - acc_list[0], 12);
        step();

        // Reset in the middle of ACCESS of a read.
        cfg_stuck = 1'b1;
        issue(1'b0, 32'h0000_E010, 32'h0, 4'hF, 1'b0);
        step();
        chk("rst_in_access", penable, 1);
        #3 preset = 1'b1;
        #1 check_all_zero("midrst");
        step();
        step();
        chk("midrst_no_rsp", rsp_valid, 0);
        preset = 1'b0;
        cfg_stuck = 1'b0; cfg_wait = 1; cfg_rdata = 32'h0F0F_1234;
        step();
        issue(1'b0, 32'h0000_E014, 32'h0, 4'hF, 1'b0);
        wait_rsp(20, pen);
        chk("post_rst_penable", pen, 2);
        chk("post_rst_rdata", rsp_rdata, 32'h0F0F_1234);
        chk("post_rst_err", rsp_err, 0);
        repeat (4) step();
        chk("final_rsp_drained", rsp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
